// File: rtl/hc04_echo_model.sv
// Multi-channel HC-SR04 emulator: checks trigger width, waits a fixed gap, then drives a programmable echo pulse.
// Latency: echo rises GAP cycles after the edge that first samples the trigger low; free-running, no backpressure.
module hc04_echo_model #(
    parameter int CHANNELS    = 4,
    parameter int MIN_TRIG    = 500,
    parameter int GAP         = 50,
    parameter int TIMEOUT_LEN = 1900000,
    parameter int LEN_W       = 21,
    localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] hc04_trigger,
    output logic [CHANNELS-1:0] hc04_echo,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [LEN_W-1:0]    cfg_len,
    input  logic [1:0]          cfg_mode,
    input  logic [CHANNELS-1:0] err_clr,
    output logic [CHANNELS-1:0] err_short,
    output logic [CHANNELS-1:0] err_overlap,
    output logic [CHANNELS-1:0] busy
);

    // One counter serves trigger width, gap and echo length, so it must cover all three.
    localparam int CW_A  = (LEN_W > 17) ? LEN_W : 17;
    localparam int CNT_W = ($clog2(MIN_TRIG + 1) > CW_A) ? $clog2(MIN_TRIG + 1) : CW_A;
    localparam logic [CH_W:0] CH_LIM = (CH_W + 1)'(CHANNELS);

    typedef enum logic [1:0] {S_IDLE, S_TRIG, S_GAP, S_ECHO} state_t;

    logic [LEN_W-1:0] cfg_len_reg  [CHANNELS];
    logic [1:0]       cfg_mode_reg [CHANNELS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cfg_len_reg[i]  <= '0;
                cfg_mode_reg[i] <= '0;
            end
        end else if (cfg_we && ({1'b0, cfg_ch} < CH_LIM)) begin
            cfg_len_reg[cfg_ch]  <= cfg_len;
            cfg_mode_reg[cfg_ch] <= cfg_mode;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [LEN_W-1:0] len_q, len_d, eff_len;
        logic             echo_q, echo_d;
        logic             trig_q, arm_q;
        logic             short_q, ovl_q, short_set, ovl_set;
        logic             rise, fall;

        // arm_q masks the first cycle after reset so a trigger held across release is not a rise.
        assign rise = hc04_trigger[i] & ~trig_q & arm_q;
        assign fall = ~hc04_trigger[i] & trig_q;

        always_comb begin
            case (cfg_mode_reg[i])
                2'd1:    eff_len = '0;
                2'd2:    eff_len = LEN_W'(TIMEOUT_LEN);
                default: eff_len = cfg_len_reg[i];
            endcase
        end

        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            len_d     = len_q;
            echo_d    = echo_q;
            short_set = 1'b0;
            ovl_set   = 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (rise) begin
                        state_d = S_TRIG;
                        cnt_d   = CNT_W'(1);
                    end
                end
                S_TRIG: begin
                    if (fall) begin
                        if (cnt_q < CNT_W'(MIN_TRIG)) begin
                            short_set = 1'b1;
                            state_d   = S_IDLE;
                            cnt_d     = '0;
                        end else begin
                            state_d = S_GAP;
                            cnt_d   = CNT_W'(1);
                            len_d   = eff_len;
                        end
                    end else if (cnt_q < CNT_W'(MIN_TRIG)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_GAP: begin
                    ovl_set = rise;
                    if (cnt_q == CNT_W'(GAP)) begin
                        cnt_d = CNT_W'(1);
                        if (len_q == '0) begin
                            state_d = S_IDLE;
                            cnt_d   = '0;
                        end else begin
                            state_d = S_ECHO;
                            echo_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_ECHO: begin
                    ovl_set = rise;
                    if (cnt_q == CNT_W'(len_q)) begin
                        state_d = S_IDLE;
                        echo_d  = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    echo_d  = 1'b0;
                    cnt_d   = '0;
                end
            endcase
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
                len_q   <= '0;
                echo_q  <= 1'b0;
                trig_q  <= 1'b0;
                arm_q   <= 1'b0;
                short_q <= 1'b0;
                ovl_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                len_q   <= len_d;
                echo_q  <= echo_d;
                trig_q  <= hc04_trigger[i];
                arm_q   <= 1'b1;
                short_q <= short_set | (short_q & ~err_clr[i]);
                ovl_q   <= ovl_set | (ovl_q & ~err_clr[i]);
            end
        end

        assign hc04_echo[i]   = echo_q;
        assign err_short[i]   = short_q;
        assign err_overlap[i] = ovl_q;
        assign busy[i]        = (state_q == S_GAP) || (state_q == S_ECHO);
    end

endmodule

// File: tb/tb_hc04_echo_model.sv
// Scoreboarded bench for hc04_echo_model: stimulus pushes predicted echo pulses, a monitor pops them per channel.
module tb_hc04_echo_model;
    localparam int CH       = 4;
    localparam int MIN_TRIG = 500;
    localparam int GAP      = 50;
    localparam int TO_LEN   = 2000;
    localparam int LEN_W    = 21;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [CH-1:0]    hc04_trigger = '0;
    logic [CH-1:0]    hc04_echo;
    logic             cfg_we = 1'b0;
    logic [1:0]       cfg_ch = '0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic [1:0]       cfg_mode = '0;
    logic [CH-1:0]    err_clr = '0;
    logic [CH-1:0]    err_short, err_overlap, busy;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {int rise; int len;} exp_t;
    exp_t exp_q [CH][$];

    hc04_echo_model #(
        .CHANNELS(CH), .MIN_TRIG(MIN_TRIG), .GAP(GAP), .TIMEOUT_LEN(TO_LEN), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hc04_trigger(hc04_trigger), .hc04_echo(hc04_echo),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_len(cfg_len), .cfg_mode(cfg_mode),
        .err_clr(err_clr), .err_short(err_short), .err_overlap(err_overlap), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: what a sensor cycle should produce, -1 meaning no echo at all.
    function automatic int model_len(input int high, input int mode, input int len);
        if (high < MIN_TRIG) return -1;
        if (mode == 1) return -1;
        if (mode == 2) return TO_LEN;
        return (len == 0) ? -1 : len;
    endfunction

    // Monitor: measures each echo pulse (first high sample, high count) and scores it.
    logic [CH-1:0] echo_prev = '0;
    int mon_rise [CH];
    int mon_len  [CH];
    always @(negedge clk) begin
        for (int c = 0; c < CH; c++) begin
            if (hc04_echo[c] === 1'b1) begin
                if (echo_prev[c] !== 1'b1) begin
                    mon_rise[c] = cyc;
                    mon_len[c]  = 0;
                end
                mon_len[c]++;
            end else if (echo_prev[c] === 1'b1) begin
                if (exp_q[c].size() == 0) begin
                    check($sformatf("unexpected_echo_ch%0d", c), 64'(mon_len[c]), 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q[c].pop_front();
                    check($sformatf("echo_rise_ch%0d", c), 64'(mon_rise[c]), 64'(e.rise));
                    check($sformatf("echo_len_ch%0d", c), 64'(mon_len[c]), 64'(e.len));
                end
            end
        end
        echo_prev = hc04_echo;
    end

    task automatic expect_echo(input int ch, input int rise, input int len);
        exp_t e;
        e.rise = rise;
        e.len  = len;
        exp_q[ch].push_back(e);
    endtask

    task automatic cfg(input int ch, input int len, input int mode);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_ch   = 2'(ch);
        cfg_len  = LEN_W'(len);
        cfg_mode = 2'(mode);
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    // Returns at the negedge just before the edge that first samples the trigger low.
    task automatic pulse(input logic [CH-1:0] mask, input int n, output int fall_edge);
        @(negedge clk);
        hc04_trigger = hc04_trigger | mask;
        repeat (n) @(negedge clk);
        hc04_trigger = hc04_trigger & ~mask;
        fall_edge = cyc + 1;
    endtask

    task automatic run_op(input int ch, input int len, input int mode, input int high);
        int f, e;
        cfg(ch, len, mode);
        pulse(CH'(1 << ch), high, f);
        e = model_len(high, mode, len);
        if (e > 0) expect_echo(ch, f + GAP, e);
    endtask

    task automatic clr_err(input logic [CH-1:0] m);
        @(negedge clk);
        err_clr = m;
        @(negedge clk);
        err_clr = '0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy !== '0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) check("wait_idle_timeout", 64'(busy), 64'd0);
        @(negedge clk);
    endtask

    task automatic wait_echo(input int ch, output int r);
        int n = 0;
        while (hc04_echo[ch] !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) check("wait_echo_timeout", 64'(hc04_echo[ch]), 64'd1);
        r = cyc;
    endtask

    task automatic busy_len(input int ch, output int n);
        int t = 0;
        n = 0;
        while (t < 2000) begin
            @(negedge clk);
            t++;
            if (busy[ch] === 1'b1) n++;
            else if (n > 0) break;
        end
    endtask

    initial begin
        int f, r, n, k;
        int ch, len, mode, high;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_echo", 64'(hc04_echo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err_short", 64'(err_short), 64'd0);
        check("rst_err_overlap", 64'(err_overlap), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic 600-cycle trigger, 1000-cycle echo
        run_op(0, 1000, 0, 600);
        wait_idle();
        check("basic_err_short", 64'(err_short), 64'd0);
        check("basic_err_overlap", 64'(err_overlap), 64'd0);

        // Trigger-width boundary: 499 short, 500 accepted
        run_op(0, 1000, 0, 499);
        repeat (GAP + 5) @(negedge clk);
        check("short499_flag", 64'(err_short[0]), 64'd1);
        check("short499_busy", 64'(busy[0]), 64'd0);
        clr_err(4'b0001);
        check("short_clr", 64'(err_short[0]), 64'd0);
        run_op(0, 1000, 0, 500);
        wait_idle();
        check("exact500_err_short", 64'(err_short[0]), 64'd0);

        // No-echo mode: busy for exactly GAP cycles; then max-echo mode
        cfg(1, 77, 1);
        pulse(4'b0010, 600, f);
        busy_len(1, n);
        check("mode1_busy_len", 64'(n), 64'(GAP));
        run_op(1, 77, 2, 600);
        wait_idle();

        // Overlap during echo, config written mid-echo only affects the next cycle
        cfg(2, 300, 0);
        pulse(4'b0100, 500, f);
        expect_echo(2, f + GAP, 300);
        wait_echo(2, r);
        repeat (100) @(negedge clk);
        cfg(2, 40, 0);
        pulse(4'b0100, 20, f);
        repeat (2) @(negedge clk);
        check("ovl_flag", 64'(err_overlap[2]), 64'd1);
        check("ovl_no_short", 64'(err_short[2]), 64'd0);
        wait_idle();
        clr_err(4'b0100);
        check("ovl_clr", 64'(err_overlap[2]), 64'd0);
        pulse(4'b0100, 500, f);
        expect_echo(2, f + GAP, 40);
        wait_echo(2, r);
        while (cyc < r + 39) @(negedge clk);
        hc04_trigger[2] = 1'b1;       // sampled on the edge where the echo ends
        repeat (600) @(negedge clk);
        hc04_trigger[2] = 1'b0;
        repeat (GAP + 10) @(negedge clk);
        check("ovl_end_flag", 64'(err_overlap[2]), 64'd1);
        check("ovl_end_busy", 64'(busy[2]), 64'd0);
        clr_err(4'b0100);

        // All channels at once
        cfg(0, 10, 0);
        cfg(1, 20, 0);
        cfg(2, 30, 0);
        cfg(3, 40, 0);
        pulse(4'b1111, 500, f);
        for (int c = 0; c < CH; c++) expect_echo(c, f + GAP, 10 * (c + 1));
        wait_idle();

        // Reset mid-echo with flags set and a trigger held across release
        cfg(3, 1000, 0);
        pulse(4'b1000, 500, f);
        wait_echo(3, r);
        pulse(4'b0001, 10, f);
        repeat (3) @(negedge clk);
        check("pre_rst_short", 64'(err_short[0]), 64'd1);
        hc04_trigger[3] = 1'b1;
        repeat (3) @(negedge clk);
        check("pre_rst_ovl", 64'(err_overlap[3]), 64'd1);
        k = cyc;
        expect_echo(3, r, k + 1 - r);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_echo", 64'(hc04_echo), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_err_short", 64'(err_short), 64'd0);
        check("midrst_err_overlap", 64'(err_overlap), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (100) begin
            @(negedge clk);
            if (busy[3] === 1'b1) n++;
        end
        check("held_trig_no_cycle", 64'(n), 64'd0);
        hc04_trigger[3] = 1'b0;
        @(negedge clk);
        pulse(4'b1000, 500, f);   // config was cleared: length 0 means gap only
        busy_len(3, n);
        check("rst_cfg_cleared", 64'(n), 64'(GAP));
        wait_idle();

        // Randomized operations against the reference model
        for (int it = 0; it < 10; it++) begin
            ch   = $urandom_range(0, CH - 1);
            len  = $urandom_range(0, 60);
            mode = $urandom_range(0, 3);
            high = $urandom_range(MIN_TRIG - 5, MIN_TRIG + 5);
            run_op(ch, len, mode, high);
            wait_idle();
            check($sformatf("rand%0d_err_short", it), 64'(err_short[ch]), 64'(high < MIN_TRIG));
            clr_err(4'b1111);
        end

        repeat (5) @(negedge clk);
        for (int c = 0; c < CH; c++)
            check($sformatf("pending_ch%0d", c), 64'(exp_q[c].size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit, got %0d cycles", cyc);
        $fatal(1);
    end

endmodule

// File: doc/hc04_echo_model.md
HC04_ECHO_MODEL -- requirements
Module: hc04_echo_model

Interface
Parameters:
REQ-001 SHALL have parameter CHANNELS, default 4: number of independent sensor channels.
REQ-002 SHALL have parameter MIN_TRIG, default 500: minimum trigger high time in clk cycles (10 us at 50 MHz).
REQ-003 SHALL have parameter GAP, default 50: clk cycles from trigger fall to echo rise (1 us at 50 MHz); legal range 1..65535.
REQ-004 SHALL have parameter TIMEOUT_LEN, default 1900000: echo length in max-echo mode (38 ms at 50 MHz).
REQ-005 SHALL have parameter LEN_W, default 21: width of echo-length values; the width SHALL hold TIMEOUT_LEN.
Ports:
REQ-006 SHALL have port clk, input, 1 bit: single clock; all state on rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-008 SHALL have port hc04_trigger, input, CHANNELS bits: per-channel trigger from the DUT, synchronous to clk.
REQ-009 SHALL have port hc04_echo, output, CHANNELS bits: per-channel emulated echo.
REQ-010 SHALL have port cfg_we, input, 1 bit: configuration write strobe.
REQ-011 SHALL have port cfg_ch, input, $clog2(CHANNELS) bits (minimum 1): channel selected for the write.
REQ-012 SHALL have port cfg_len, input, LEN_W bits: echo length in clk cycles.
REQ-013 SHALL have port cfg_mode, input, 2 bits: 0 = normal, 1 = no-echo, 2 = max-echo, 3 = reserved and treated as 0.
REQ-014 SHALL have port err_clr, input, CHANNELS bits: per-channel clear of the error flags.
REQ-015 SHALL have port err_short, output, CHANNELS bits: sticky flag, trigger pulse too short.
REQ-016 SHALL have port err_overlap, output, CHANNELS bits: sticky flag, trigger rose while the channel was busy.
REQ-017 SHALL have port busy, output, CHANNELS bits: channel is in state GAP or ECHO.

Function
REQ-018 Each channel SHALL run an independent FSM with states IDLE, TRIG, GAP, ECHO; busy[i] = (state is GAP or ECHO).
REQ-019 Each channel SHALL register hc04_trigger into trig_q.
- Rise: trig & ~trig_q.
- Fall: ~trig & trig_q.
REQ-020 IDLE: on a rise, the FSM SHALL enter TRIG with cnt = 1.
REQ-021 TRIG: cnt SHALL increment each cycle the trigger stays high and saturate at MIN_TRIG.
- On fall with cnt < MIN_TRIG: set err_short[i] and go to IDLE; no echo is produced.
- On fall with cnt >= MIN_TRIG: go to GAP with cnt = 1.
- cnt therefore equals the number of cycles the trigger was high.
REQ-022 On TRIG->GAP, the FSM SHALL latch the effective length.
- Mode 0 or 3: cfg_len_reg[i].
- Mode 1: 0.
- Mode 2: TIMEOUT_LEN.
REQ-023 GAP: after GAP cycles in GAP, the FSM SHALL go to ECHO, or to IDLE if the latched length is 0.
- hc04_echo[i] rises exactly GAP cycles after the clk edge that first samples the trigger low.
REQ-024 ECHO: hc04_echo[i] SHALL be high for exactly the latched length in cycles, then go low and the FSM returns to IDLE.
- hc04_echo is a registered output with no glitches.
REQ-025 A rise in GAP or ECHO SHALL set err_overlap[i] and be ignored; the current cycle completes unchanged.
REQ-026 A rise in the cycle where ECHO ends SHALL be treated as occurring in ECHO: it is ignored and flagged.
REQ-027 A config write SHALL update cfg_len_reg/cfg_mode_reg of channel cfg_ch on the next edge.
- Writes never affect an in-flight GAP/ECHO, which uses the latched length.
- A write with cfg_ch >= CHANNELS is ignored.
REQ-028 When a set and err_clr[i] coincide in the same cycle, set SHALL win.
REQ-029 Channels SHALL share no state other than the config write port.

Reset
REQ-030 While rst_n = 0 at a clk edge, the block SHALL clear all of the following:
- every FSM to IDLE;
- hc04_echo, busy, err_short, err_overlap to 0;
- trig_q and cnt to 0;
- cfg_len_reg to 0 and cfg_mode_reg to 0.
REQ-031 Reset mid-ECHO SHALL drop hc04_echo low on the same edge.
- A trigger held high across reset release is not a rise and produces no cycle.

Verification
REQ-032 Bench SHALL cover: cfg ch0 len=1000 mode 0; trigger high 600 cycles -> echo rises 50 cycles after the fall edge, high exactly 1000 cycles, err flags 0.
REQ-033 Bench SHALL cover: trigger high 499 cycles -> err_short[0]=1, no echo; err_clr[0] pulse -> err_short[0]=0; repeat with exactly 500 cycles -> echo produced.
REQ-034 Bench SHALL cover: mode 1 on ch1 with a 600-cycle trigger -> busy for 50 cycles, echo stays 0; mode 2 -> echo high exactly TIMEOUT_LEN cycles.
REQ-035 Bench SHALL cover: second trigger during ECHO of ch2 -> err_overlap[2]=1, echo length unchanged; cfg write to ch2 mid-echo -> applied only to the next cycle.
REQ-036 Bench SHALL cover: all 4 channels triggered simultaneously with lens 10/20/30/40 -> independent echoes of exactly those lengths.
REQ-037 Bench SHALL cover: rst_n low mid-echo -> echo and all flags 0 on the same edge; trigger held high through release -> no echo.
